// File: rtl/vga_sync_monitor.sv
// VGA timing monitor: turns the pixel clock into clk-domain strobes, captures
// active pixel coordinates and checks line/frame geometry to acquire lock.
module vga_sync_monitor #(
  parameter int H_TOTAL  = 800,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vga_clk,
  input  logic       vga_hs,
  input  logic       vga_vs,
  input  logic       vga_blank_n,
  input  logic       clr_err,
  output logic       pix_valid,
  output logic [9:0] px_x,
  output logic [8:0] px_y,
  output logic       frame_done,
  output logic       locked,
  output logic       err_h,
  output logic       err_v
);
  typedef enum logic [1:0] {SEARCH = 2'd0, ALIGN = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [9:0] H_TOTAL_C  = 10'(H_TOTAL);
  localparam logic [9:0] H_ACTIVE_C = 10'(H_ACTIVE);
  localparam logic [9:0] V_TOTAL_C  = 10'(V_TOTAL);
  localparam logic [8:0] V_ACTIVE_C = 9'(V_ACTIVE);
  localparam logic [9:0] CNT_MAX    = 10'd1023;
  localparam logic [8:0] VLINE_MAX  = 9'd511;

  state_t     state_q, state_d;
  logic       vclk_q, vclk_d, vclk_prev_q, vclk_prev_d;
  logic       hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [9:0] hcnt_q, hcnt_d, acnt_q, acnt_d, tline_q, tline_d;
  logic [8:0] vline_q, vline_d;
  logic       skip_q, skip_d, frame_lerr_q, frame_lerr_d;
  logic       pix_valid_q, pix_valid_d, frame_done_q, frame_done_d;
  logic       locked_q, locked_d, err_h_q, err_h_d, err_v_q, err_v_d;
  logic [9:0] px_x_q, px_x_d;
  logic [8:0] px_y_q, px_y_d;

  logic       strobe_s, hs_fall_s, vs_fall_s, pix_s;
  logic       check_s, line_err_s, lerr_upd_s, cnt_ok_s, set_h_s, set_v_s;
  logic [9:0] tline_upd_s;
  logic [8:0] vline_upd_s;

  // Strobe detection, line/frame measurement, lock FSM and output staging.
  always_comb begin
    strobe_s  = vclk_q & ~vclk_prev_q;
    hs_fall_s = strobe_s & hs_prev_q & ~vga_hs;
    vs_fall_s = strobe_s & vs_prev_q & ~vga_vs;
    pix_s     = strobe_s & vga_blank_n;

    vclk_d      = vga_clk;
    vclk_prev_d = vclk_q;
    hs_prev_d   = strobe_s ? vga_hs : hs_prev_q;
    vs_prev_d   = strobe_s ? vga_vs : vs_prev_q;

    if (hs_fall_s) begin
      hcnt_d = 10'd1;
    end else if (strobe_s && (hcnt_q != CNT_MAX)) begin
      hcnt_d = hcnt_q + 10'd1;
    end else begin
      hcnt_d = hcnt_q;
    end

    if (hs_fall_s) begin
      acnt_d = 10'd0;
    end else if (pix_s && (acnt_q != CNT_MAX)) begin
      acnt_d = acnt_q + 10'd1;
    end else begin
      acnt_d = acnt_q;
    end

    // The line closing at this hs_fall is evaluated before any frame decision.
    check_s    = hs_fall_s && (state_q != SEARCH) && !((state_q == ALIGN) && skip_q);
    line_err_s = check_s && ((hcnt_q != H_TOTAL_C) ||
                             ((acnt_q != 10'd0) && (acnt_q != H_ACTIVE_C)));

    vline_upd_s = (hs_fall_s && (acnt_q != 10'd0) && (vline_q != VLINE_MAX)) ?
                  vline_q + 9'd1 : vline_q;
    tline_upd_s = (hs_fall_s && (tline_q != CNT_MAX)) ? tline_q + 10'd1 : tline_q;
    lerr_upd_s  = frame_lerr_q | line_err_s;
    cnt_ok_s    = (tline_upd_s == V_TOTAL_C) && (vline_upd_s == V_ACTIVE_C);

    vline_d      = vs_fall_s ? 9'd0 : vline_upd_s;
    tline_d      = vs_fall_s ? 10'd0 : tline_upd_s;
    frame_lerr_d = vs_fall_s ? 1'b0 : lerr_upd_s;

    state_d = state_q;
    skip_d  = (hs_fall_s && (state_q == ALIGN)) ? 1'b0 : skip_q;
    set_h_s = 1'b0;
    set_v_s = 1'b0;
    case (state_q)
      SEARCH: begin
        if (vs_fall_s) begin
          state_d = ALIGN;
          skip_d  = 1'b1;
        end else begin
          state_d = SEARCH;
        end
      end
      ALIGN: begin
        if (vs_fall_s && cnt_ok_s && !lerr_upd_s) begin
          state_d = LOCKED;
        end else begin
          state_d = ALIGN;
        end
      end
      LOCKED: begin
        set_h_s = line_err_s;
        set_v_s = vs_fall_s && !cnt_ok_s;
        state_d = (set_h_s || set_v_s) ? SEARCH : LOCKED;
      end
      default: begin
        state_d = SEARCH;
      end
    endcase

    pix_valid_d  = pix_s && (state_q != SEARCH);
    px_x_d       = pix_s ? acnt_q : px_x_q;
    px_y_d       = pix_s ? vline_q : px_y_q;
    frame_done_d = vs_fall_s && (state_q != SEARCH);
    locked_d     = (state_d == LOCKED);
    // A set in the same cycle as clr_err keeps the flag.
    err_h_d      = set_h_s ? 1'b1 : (clr_err ? 1'b0 : err_h_q);
    err_v_d      = set_v_s ? 1'b1 : (clr_err ? 1'b0 : err_v_q);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SEARCH;
      vclk_q       <= 1'b0;
      vclk_prev_q  <= 1'b0;
      hs_prev_q    <= 1'b1;
      vs_prev_q    <= 1'b1;
      hcnt_q       <= 10'd0;
      acnt_q       <= 10'd0;
      tline_q      <= 10'd0;
      vline_q      <= 9'd0;
      skip_q       <= 1'b0;
      frame_lerr_q <= 1'b0;
      pix_valid_q  <= 1'b0;
      px_x_q       <= 10'd0;
      px_y_q       <= 9'd0;
      frame_done_q <= 1'b0;
      locked_q     <= 1'b0;
      err_h_q      <= 1'b0;
      err_v_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      vclk_q       <= vclk_d;
      vclk_prev_q  <= vclk_prev_d;
      hs_prev_q    <= hs_prev_d;
      vs_prev_q    <= vs_prev_d;
      hcnt_q       <= hcnt_d;
      acnt_q       <= acnt_d;
      tline_q      <= tline_d;
      vline_q      <= vline_d;
      skip_q       <= skip_d;
      frame_lerr_q <= frame_lerr_d;
      pix_valid_q  <= pix_valid_d;
      px_x_q       <= px_x_d;
      px_y_q       <= px_y_d;
      frame_done_q <= frame_done_d;
      locked_q     <= locked_d;
      err_h_q      <= err_h_d;
      err_v_q      <= err_v_d;
    end
  end

  assign pix_valid  = pix_valid_q;
  assign px_x       = px_x_q;
  assign px_y       = px_y_q;
  assign frame_done = frame_done_q;
  assign locked     = locked_q;
  assign err_h      = err_h_q;
  assign err_v      = err_v_q;
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a scaled-down 20x12 raster
// (8x6 active, hsync at columns 10..13, vsync on lines 7..8).
module tb_vga_sync_monitor;
  localparam int HT = 20;
  localparam int HA = 8;
  localparam int VT = 12;
  localparam int VA = 6;
  localparam int HS_START = 10;
  localparam int HS_END   = 14;

  logic       clk = 1'b0;
  logic       reset, vga_clk, vga_hs, vga_vs, vga_blank_n, clr_err;
  logic       pix_valid, frame_done, locked, err_h, err_v;
  logic [9:0] px_x;
  logic [8:0] px_y;

  int n_assert = 0;
  int n_fail   = 0;
  int pix_cnt  = 0;
  int fd_cnt   = 0;
  int bad_px   = 0;
  int ex       = 0;
  int ey       = 0;
  logic vs_seen = 1'b1;
  int p0, f0;

  vga_sync_monitor #(.H_TOTAL(HT), .H_ACTIVE(HA), .V_TOTAL(VT), .V_ACTIVE(VA)) dut (
    .clk(clk), .reset(reset), .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .clr_err(clr_err), .pix_valid(pix_valid),
    .px_x(px_x), .px_y(px_y), .frame_done(frame_done), .locked(locked),
    .err_h(err_h), .err_v(err_v)
  );

  always #5 clk = ~clk;

  // Pixel/frame scoreboard: expected coordinates restart when the driven vsync falls.
  always @(posedge clk) begin
    #1;
    if (vs_seen && !vga_vs) begin
      ex = 0;
      ey = 0;
    end
    vs_seen = vga_vs;
    if (pix_valid) begin
      pix_cnt++;
      if ((px_x !== 10'(ex)) || (px_y !== 9'(ey))) bad_px++;
      ex++;
      if (ex == HA) begin
        ex = 0;
        ey++;
      end
    end
    if (frame_done) fd_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pixel period = two clk cycles; data changes together with the vga_clk rise.
  task automatic send_px(input int x, input int y, input logic clr);
    @(negedge clk);
    clr_err     = 1'b0;
    vga_hs      = !((x >= HS_START) && (x < HS_END));
    vga_vs      = !((y == 7) || (y == 8));
    vga_blank_n = (y < VA) && (x < HA);
    vga_clk     = 1'b1;
    @(negedge clk);
    vga_clk = 1'b0;
    clr_err = clr;
  endtask

  task automatic send_line(input int y, input int len);
    for (int x = 0; x < len; x++) send_px(x, y, 1'b0);
  endtask

  task automatic send_frame(input int nlines);
    for (int y = 0; y < nlines; y++) send_line(y, HT);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; vga_clk = 1'b0; vga_hs = 1'b1; vga_vs = 1'b1;
    vga_blank_n = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_px_x", px_x, 0);
    chk("rst_px_y", px_y, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err_h", err_h, 0);
    chk("rst_err_v", err_v, 0);
    reset = 1'b0;

    // Frame A: SEARCH -> ALIGN at its vsync, no pixels, no frame_done.
    p0 = pix_cnt; f0 = fd_cnt;
    send_frame(VT);
    chk("A_locked", locked, 0);
    chk("A_pix", pix_cnt - p0, 0);
    chk("A_fd", fd_cnt - f0, 0);

    // Frame B: ALIGN -> LOCKED.
    p0 = pix_cnt; f0 = fd_cnt;
    send_frame(VT);
    chk("B_locked", locked, 1);
    chk("B_pix", pix_cnt - p0, HA * VA);
    chk("B_fd", fd_cnt - f0, 1);

    // Frame C: steady lock, last captured pixel is the bottom-right corner.
    p0 = pix_cnt; f0 = fd_cnt;
    send_frame(VT);
    chk("C_locked", locked, 1);
    chk("C_pix", pix_cnt - p0, HA * VA);
    chk("C_fd", fd_cnt - f0, 1);
    chk("C_px_x_last", px_x, HA - 1);
    chk("C_px_y_last", px_y, VA - 1);
    chk("C_err_h", err_h, 0);
    chk("C_err_v", err_v, 0);
    chk("C_px_order", bad_px, 0);

    // vga_clk frozen while syncs toggle: nothing may move.
    p0 = pix_cnt; f0 = fd_cnt;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      vga_hs = i[0]; vga_vs = i[1]; vga_blank_n = i[2];
    end
    @(negedge clk);
    vga_hs = 1'b1; vga_vs = 1'b1; vga_blank_n = 1'b0;
    chk("frz_pix", pix_cnt - p0, 0);
    chk("frz_fd", fd_cnt - f0, 0);
    chk("frz_locked", locked, 1);

    // Frame D: line 2 one pixel short; error flagged at the hs_fall closing it.
    f0 = fd_cnt;
    send_line(0, HT);
    send_line(1, HT);
    send_line(2, HT - 1);
    chk("D_pre_err_h", err_h, 0);
    chk("D_pre_locked", locked, 1);
    for (int x = 0; x <= HS_START; x++) send_px(x, 3, 1'b0);
    after_edge();
    chk("D_err_h", err_h, 1);
    chk("D_locked", locked, 0);
    for (int x = HS_START + 1; x < HT; x++) send_px(x, 3, 1'b0);
    for (int y = 4; y < VT; y++) send_line(y, HT);
    chk("D_err_h_sticky", err_h, 1);
    chk("D_fd", fd_cnt - f0, 0);
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    chk("D_clr_err_h", err_h, 0);

    // Frame E: relock from ALIGN.
    p0 = pix_cnt;
    send_frame(VT);
    chk("E_locked", locked, 1);
    chk("E_pix", pix_cnt - p0, HA * VA);

    // Frame F has 11 lines; mismatch seen at the vsync falling edge in frame G.
    send_frame(VT - 1);
    f0 = fd_cnt;
    for (int y = 0; y < 7; y++) send_line(y, HT);
    send_px(0, 7, 1'b0);
    after_edge();
    chk("G_err_v", err_v, 1);
    chk("G_locked", locked, 0);
    chk("G_frame_done", frame_done, 1);
    chk("G_err_h", err_h, 0);
    for (int x = 1; x < HT; x++) send_px(x, 7, 1'b0);
    for (int y = 8; y < VT; y++) send_line(y, HT);
    chk("G_fd", fd_cnt - f0, 1);

    // Frames H, I: reacquire; err_v stays sticky.
    send_frame(VT);
    send_frame(VT);
    chk("I_locked", locked, 1);
    chk("I_err_v_sticky", err_v, 1);

    // Frame J: clr_err coincides with a new line error.
    send_line(0, HT);
    send_line(1, HT);
    send_line(2, HT - 1);
    for (int x = 0; x < HS_START; x++) send_px(x, 3, 1'b0);
    send_px(HS_START, 3, 1'b1);
    after_edge();
    chk("J_err_h_wins", err_h, 1);
    chk("J_err_v_cleared", err_v, 0);
    chk("J_locked", locked, 0);
    for (int x = HS_START + 1; x < HT; x++) send_px(x, 3, 1'b0);
    for (int y = 4; y < VT; y++) send_line(y, HT);

    // Frame K relocks; frame M is cut by a reset after line 2.
    send_frame(VT);
    send_line(0, HT);
    send_line(1, HT);
    send_line(2, HT);
    chk("M_pre_locked", locked, 1);
    chk("M_pre_err_h", err_h, 1);
    reset = 1'b1;
    #1;
    chk("M_rst_locked", locked, 0);
    chk("M_rst_err_h", err_h, 0);
    chk("M_rst_px_x", px_x, 0);
    chk("M_rst_pix_valid", pix_valid, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    f0 = fd_cnt;
    for (int y = 3; y < VT; y++) send_line(y, HT);
    chk("M_locked", locked, 0);
    chk("M_fd", fd_cnt - f0, 0);
    send_frame(VT);
    chk("N_locked", locked, 1);
    chk("N_err_h", err_h, 0);
    chk("N_px_order", bad_px, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_sync_monitor.md
VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 H_TOTAL, 800, pixel clocks per line (active + porches + sync).
REQ-002 H_ACTIVE, 640, active pixels per line.
REQ-003 V_TOTAL, 525, lines per frame.
REQ-004 V_ACTIVE, 480, active lines per frame.
REQ-005 clk  input  1  system clock, CLOCK_50 domain, all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high; clears all state.
REQ-007 vga_clk  input  1  VGA pixel clock as driven on VGA_CLK (clk/2 nominal).
REQ-008 vga_hs  input  1  horizontal sync, active low.
REQ-009 vga_vs  input  1  vertical sync, active low.
REQ-010 vga_blank_n  input  1  high during active video.
REQ-011 clr_err  input  1  synchronous clear of sticky error flags.
REQ-012 pix_valid  output  1  one-clk pulse per captured active pixel.
REQ-013 px_x  output  10  column of captured pixel, 0..H_ACTIVE-1.
REQ-014 px_y  output  9  row of captured pixel, 0..V_ACTIVE-1.
REQ-015 frame_done  output  1  one-clk pulse at each vsync falling edge when not in SEARCH.
REQ-016 locked  output  1  high while state is LOCKED.
REQ-017 err_h  output  1  sticky: bad line length or bad active-pixel count.
REQ-018 err_v  output  1  sticky: bad frame line count or bad active-line count.

Function
REQ-019 Strobe: vga_clk registered once into clk domain; strobe asserted when current vga_clk sample is 1 and previous sample is 0; hs, vs, blank_n are sampled only on strobe cycles.
REQ-020 Previous-sample registers for hs and vs update on strobe; hs_fall and vs_fall are derived from strobe samples only (1 then 0).
REQ-021 hcnt increments per strobe, saturates at 1023, reloads to 1 at hs_fall; the value just before reload is the measured line length.
REQ-022 acnt counts strobes with blank_n=1 within a line, saturates at 1023, clears at hs_fall.
REQ-023 On a strobe with blank_n=1: px_x=acnt, px_y=active-line count; pix_valid pulses the following clk cycle (latency 1 clk after the strobe), with px_x/px_y held stable alongside it.
REQ-024 Active-line counter increments at hs_fall when the ending line had acnt>0, saturates at 511, clears at vs_fall.
REQ-025 Total-line counter increments at each hs_fall, saturates at 1023, clears at vs_fall.
REQ-026 States: SEARCH, ALIGN, LOCKED; SEARCH->ALIGN on first vs_fall.
REQ-027 ALIGN->LOCKED on next vs_fall if the completed frame had no line error and total lines == V_TOTAL and active lines == V_ACTIVE; otherwise remain in ALIGN.
REQ-028 Line error at hs_fall (outside SEARCH, excluding the first hs_fall after entering ALIGN): measured length != H_TOTAL, or acnt not in {0, H_ACTIVE}.
REQ-029 In LOCKED: line error sets err_h; frame mismatch at vs_fall sets err_v; either one forces LOCKED->SEARCH in the same cycle.
REQ-030 pix_valid is suppressed in SEARCH; counters run in all states.
REQ-031 err_h/err_v are set only from LOCKED, and clear only on reset or clr_err; a set event in the same cycle as clr_err wins (flag stays 1).
REQ-032 Simultaneous hs_fall and vs_fall on one strobe: the line is processed first (line checks, counter increments), then the frame checks use the updated counts, then frame counters clear.

Reset
REQ-033 During reset: state=SEARCH; all counters and sync-sample registers 0 (hs/vs previous samples 1); pix_valid=0, px_x=0, px_y=0, frame_done=0, locked=0, err_h=0, err_v=0.
REQ-034 Reset asserted mid-frame aborts the frame; after release, the block re-enters ALIGN only at the next vs_fall.

Verification
REQ-035 Nominal 640x480@60 stream, vga_clk=clk/2 -> ALIGN at 1st vs_fall, locked=1 at 2nd; per frame 307200 pix_valid pulses, px_x 0..639, px_y 0..479, one frame_done per 420000 strobes.
REQ-036 Locked, then one line of 799 strobes -> err_h=1 and locked=0 at that hs_fall; err_h stays 1 until clr_err.
REQ-037 Locked, then frame of 524 lines -> err_v=1, state SEARCH, frame_done still pulses once.
REQ-038 vga_clk held constant while hs/vs toggle -> no strobes, pix_valid=0, counters frozen.
REQ-039 Reset pulse at line 200 -> all outputs 0 immediately; locked=1 again two vs_falls later.
REQ-040 clr_err in the same cycle as a new line error -> err_h reads 1 next cycle.
